bram_capture_ctrl: RTL and testbench
====================================

Name: bram_capture_ctrl

Overview:
- Sample-capture buffer for debug logging of equalizer signals (e.g. error, taps, slicer output) into on-chip BRAM.
- Downstream consumer of the BRAM address-count stage: generates write addresses internally, sequences arm/trigger/capture/done, and exposes a registered read port for host readout.
- Contains the inferred simple dual-port memory; the write side is owned by the FSM, the read side is owned by the host.

Parameters:
- DEPTH, 1024, number of capture words; any value >= 2, not restricted to a power of two.
- DATA_W, 16, sample width in bits.
- AW, $clog2(DEPTH), address width; derived, not for override.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; arms capture.
- abort  in  1  single-cycle pulse; returns to IDLE from any state.
- trig  in  1  trigger qualifier, sampled only with in_valid.
- in_valid  in  1  input sample strobe.
- in_data  in  DATA_W  input sample.
- rd_en  in  1  host read request.
- rd_addr  in  AW  host read address.
- rd_data  out  DATA_W  read data, registered.
- rd_valid  out  1  high one cycle after rd_en.
- armed  out  1  high in the ARMED state.
- busy  out  1  high in the CAPTURE state.
- done  out  1  high in the DONE state.
- wr_count  out  AW+1  number of words written in the current or last capture; range 0..DEPTH.

Behaviour:
- Reset:
  - state goes to IDLE.
  - armed, busy, done, rd_valid and wr_count are all 0.
  - rd_data is 0.
  - Memory contents are not cleared.
- FSM states are IDLE, ARMED, CAPTURE and DONE.
- IDLE:
  - start goes to ARMED and clears wr_count to 0.
- ARMED:
  - trig && in_valid writes in_data at address 0.
  - wr_count becomes 1; the next state is CAPTURE.
  - trig without in_valid is ignored.
- CAPTURE:
  - Each in_valid writes in_data at address wr_ptr; wr_ptr and wr_count both increment.
  - trig is ignored in this state.
  - A write at wr_ptr == DEPTH-1 completes the capture: the next state is DONE, wr_count = DEPTH, and wr_ptr wraps to 0.
  - There is no write beyond DEPTH-1.
- DONE:
  - Holds until start (re-arm, goes to ARMED, clears wr_count) or abort.
- abort:
  - Goes to IDLE next cycle from any state and has priority over start, trig and in_valid in the same cycle.
  - No write occurs in the abort cycle.
  - wr_count holds its value.
- start is ignored while in ARMED or CAPTURE.
- Write latency: the sample presented in cycle n is in memory at the edge ending cycle n.
- Status outputs (armed, busy, done) are decoded from registered state; there is no combinational path from the inputs.
- Read port:
  - Available in every state.
  - rd_en in cycle n gives rd_data and rd_valid = 1 in cycle n+1.
  - rd_data holds its value when rd_en = 0.
  - Read of the same address being written in the same cycle: read-first, returns the old contents.
  - Reads in CAPTURE are allowed and return whatever is stored.
  - rd_addr >= DEPTH returns an undefined value; rd_valid still asserts.
- Arithmetic:
  - wr_ptr is AW bits, compared against DEPTH-1, not against natural overflow.
  - wr_count is AW+1 bits so that DEPTH is representable.

Optional Feature:
- Macro: CAPTURE_DECIM_EN.
- When defined:
  - Adds input port decim (8 bits, static while busy).
  - In CAPTURE, only every (decim+1)-th in_valid sample is written. Qualifying samples: the trigger sample, then every (decim+1)-th valid sample after it.
  - The decimation phase counter resets on entry to ARMED.
  - decim = 0 gives identical behaviour to the undefined case.
- When undefined:
  - No decim port.
  - Every valid sample is written.

Test Plan:
- Reset then basic capture, DEPTH=8: reset; start; in_data = 0x10..0x17 with valid every cycle and trig on the first -> busy for 7 cycles, done=1, wr_count=8, reads of addr 0..7 return 0x10..0x17 with rd_valid one cycle after each rd_en.
- Trigger qualification: in ARMED, trig=1 with in_valid=0, then valid data with trig=0 for 5 cycles -> stays ARMED, wr_count=0; then trig+valid with 0xAA -> addr 0 = 0xAA, busy=1.
- Gapped input: valid asserted every 3rd cycle during CAPTURE -> wr_count increments only on valid cycles; DONE after exactly DEPTH writes; no write at DEPTH.
- Abort and priority: abort mid-capture at wr_count=4, with start and in_valid high in the same cycle -> IDLE next cycle, wr_count=4, no write; a later start -> ARMED, wr_count=0.
- Read-first collision: rd_en at addr 3 in the same cycle as the capture write to addr 3 (old 0x55, new 0x99) -> rd_data=0x55; a re-read gives 0x99.
- CAPTURE_DECIM_EN, decim=2, DEPTH=8: continuous samples 0,1,2,... with trig on 0 -> memory holds 0,3,6,...,21; done after 22 valid samples.

Source files
------------

// File: rtl/bram_capture_ctrl_if.sv
// Capture input, host read port and status bundle for bram_capture_ctrl.
// With CAPTURE_DECIM_EN defined the bundle also carries the decim input.
interface bram_capture_ctrl_if #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
);
    logic              start;
    logic              abort;
    logic              trig;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              armed;
    logic              busy;
    logic              done;
    logic [AW:0]       wr_count;
`ifdef CAPTURE_DECIM_EN
    logic [7:0]        decim;
`endif

    modport master (
        output start, abort, trig, in_valid, in_data, rd_en, rd_addr,
        input  rd_data, rd_valid, armed, busy, done, wr_count
`ifdef CAPTURE_DECIM_EN
        , output decim
`endif
    );

    modport slave (
        input  start, abort, trig, in_valid, in_data, rd_en, rd_addr,
        output rd_data, rd_valid, armed, busy, done, wr_count
`ifdef CAPTURE_DECIM_EN
        , input decim
`endif
    );
endinterface

// File: rtl/bram_capture_ctrl.sv
// Arm/trigger/capture sequencer writing samples into an inferred dual-port BRAM with a
// registered host read port. CAPTURE_DECIM_EN enables input decimation by (decim+1).
module bram_capture_ctrl #(
    parameter int unsigned  DEPTH  = 1024,
    parameter int unsigned  DATA_W = 16,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input logic                clk,
    input logic                rst,
    bram_capture_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, wr_addr;
    logic [AW:0]       wr_count_q, wr_count_d;
    logic              wr_en;
    logic              take;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

`ifdef CAPTURE_DECIM_EN
    logic [7:0] phase_q, phase_d;

    // Phase counts valid samples skipped since the last write; held at zero outside CAPTURE
    // so the trigger sample always starts a fresh decimation period.
    assign take = (phase_q == bus.decim);

    always_comb begin
        phase_d = phase_q;
        if (state_q != StCapture || bus.abort) begin
            phase_d = '0;
        end else if (bus.in_valid) begin
            phase_d = take ? 8'd0 : phase_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) phase_q <= '0;
        else     phase_q <= phase_d;
    end
`else
    assign take = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_d    = StArmed;
                        wr_ptr_d   = '0;
                        wr_count_d = '0;
                    end
                end
                StArmed: begin
                    if (bus.trig && bus.in_valid) begin
                        wr_en      = 1'b1;
                        wr_addr    = '0;
                        wr_ptr_d   = AW'(1);
                        wr_count_d = (AW+1)'(1);
                        state_d    = StCapture;
                    end
                end
                StCapture: begin
                    if (bus.in_valid && take) begin
                        wr_en      = 1'b1;
                        wr_count_d = wr_count_q + (AW+1)'(1);
                        // Explicit compare so non-power-of-two depths stop at DEPTH-1.
                        if (wr_ptr_q == AW'(DEPTH - 1)) begin
                            wr_ptr_d = '0;
                            state_d  = StDone;
                        end else begin
                            wr_ptr_d = wr_ptr_q + AW'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.in_data;
    end

    // Read-first: a same-cycle write to rd_addr lands after this sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.armed    = (state_q == StArmed);
    assign bus.busy     = (state_q == StCapture);
    assign bus.done     = (state_q == StDone);
    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Self-checking bench for bram_capture_ctrl at DEPTH=8; covers the decim path when
// CAPTURE_DECIM_EN is defined.
module tb_bram_capture_ctrl;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] want;

    bram_capture_ctrl_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    bram_capture_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs set before step() are sampled on its edge; outputs are read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.trig     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
`ifdef CAPTURE_DECIM_EN
        bus.decim    = '0;
`endif
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++;
        if ({bus.armed, bus.busy, bus.done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_status got=%b want=000", {bus.armed, bus.busy, bus.done});
        end
        total++;
        if (bus.wr_count !== 4'd0 || bus.rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_count got=%0d/%b want=0/0", bus.wr_count, bus.rd_valid);
        end
        total++;
        if (bus.rd_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_rd_data got=%h want=0000", bus.rd_data);
        end
    endtask

    task automatic test_readback(input string tag);
        for (int a = 0; a < int'(DEPTH); a++) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = 3'(a);
            sb_q.push_back(exp_mem[a]);
            step();
            want = sb_q.pop_front();
            total++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== want) begin
                bad++;
                $display("FAIL %s_read[%0d] got=%h/%b want=%h/1", tag, a, bus.rd_data,
                         bus.rd_valid, want);
            end
        end
        bus.rd_en = 1'b0;
        step();
        total++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== exp_mem[DEPTH-1]) begin
            bad++;
            $display("FAIL %s_rd_hold got=%h/%b want=%h/0", tag, bus.rd_data, bus.rd_valid,
                     exp_mem[DEPTH-1]);
        end
    endtask

    task automatic test_basic();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.armed !== 1'b1 || bus.wr_count !== 4'd0) begin
            bad++;
            $display("FAIL basic_arm got=%b/%0d want=1/0", bus.armed, bus.wr_count);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.in_valid = 1'b1;
            bus.trig     = (i == 0);
            bus.in_data  = 16'h10 + 16'(i);
            exp_mem[i]   = 16'h10 + 16'(i);
            step();
            total++;
            if (bus.busy !== (i < 7) || bus.done !== (i == 7) || bus.wr_count !== 4'(i + 1)) begin
                bad++;
                $display("FAIL basic_step[%0d] got=busy%b done%b cnt%0d want=busy%b done%b cnt%0d",
                         i, bus.busy, bus.done, bus.wr_count, (i < 7), (i == 7), i + 1);
            end
        end
        clear_inputs();
        test_readback("basic");
    endtask

    task automatic test_trig_qual();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.trig  = 1'b1;
        step();
        bus.trig = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h1000 + 16'(k);
            step();
            total++;
            if (bus.armed !== 1'b1 || bus.wr_count !== 4'd0) begin
                bad++;
                $display("FAIL trig_ignored[%0d] got=%b/%0d want=1/0", k, bus.armed, bus.wr_count);
            end
        end
        bus.trig    = 1'b1;
        bus.in_data = 16'h00AA;
        exp_mem[0]  = 16'h00AA;
        step();
        bus.trig     = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.wr_count !== 4'd1) begin
            bad++;
            $display("FAIL trig_fire got=%b/%0d want=1/1", bus.busy, bus.wr_count);
        end
    endtask

    // Continues the capture left running by test_trig_qual.
    task automatic test_gapped();
        for (int k = 1; k < int'(DEPTH); k++) begin
            bus.in_valid = 1'b0;
            step();
            step();
            total++;
            if (bus.wr_count !== 4'(k) || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL gap_idle[%0d] got=%0d/%b want=%0d/1", k, bus.wr_count, bus.busy, k);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0200 + 16'(k);
            exp_mem[k]   = 16'h0200 + 16'(k);
            step();
            total++;
            if (bus.wr_count !== 4'(k + 1) || bus.done !== (k == 7)) begin
                bad++;
                $display("FAIL gap_write[%0d] got=%0d/%b want=%0d/%b", k, bus.wr_count, bus.done,
                         k + 1, (k == 7));
            end
        end
        bus.in_data = 16'h02FF;
        step();
        step();
        bus.in_valid = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.wr_count !== 4'd8) begin
            bad++;
            $display("FAIL gap_done_hold got=%b/%0d want=1/8", bus.done, bus.wr_count);
        end
        test_readback("gapped");
    endtask

    task automatic test_abort();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.trig     = (i == 0);
            bus.in_data  = 16'h0300 + 16'(i);
            exp_mem[i]   = 16'h0300 + 16'(i);
            step();
        end
        bus.abort   = 1'b1;
        bus.start   = 1'b1;
        bus.trig    = 1'b1;
        bus.in_data = 16'hDEAD;
        step();
        clear_inputs();
        total++;
        if ({bus.armed, bus.busy, bus.done} !== 3'b000 || bus.wr_count !== 4'd4) begin
            bad++;
            $display("FAIL abort_idle got=%b/%0d want=000/4", {bus.armed, bus.busy, bus.done},
                     bus.wr_count);
        end
        step();
        total++;
        if ({bus.armed, bus.busy, bus.done} !== 3'b000 || bus.wr_count !== 4'd4) begin
            bad++;
            $display("FAIL abort_stay got=%b/%0d want=000/4", {bus.armed, bus.busy, bus.done},
                     bus.wr_count);
        end
        test_readback("abort");
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.armed !== 1'b1 || bus.wr_count !== 4'd0) begin
            bad++;
            $display("FAIL abort_rearm got=%b/%0d want=1/0", bus.armed, bus.wr_count);
        end
    endtask

    // Entered in ARMED from test_abort.
    task automatic test_collision();
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.in_valid = 1'b1;
            bus.trig     = (i == 0);
            bus.in_data  = (i == 3) ? 16'h0055 : 16'h0400 + 16'(i);
            exp_mem[i]   = bus.in_data;
            step();
        end
        clear_inputs();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.in_valid = 1'b1;
            bus.trig     = (i == 0);
            bus.in_data  = (i == 3) ? 16'h0099 : 16'h0500 + 16'(i);
            bus.rd_en    = (i == 3);
            bus.rd_addr  = 3'd3;
            if (i == 3) sb_q.push_back(exp_mem[3]);
            exp_mem[i] = bus.in_data;
            step();
            if (i == 3) begin
                want = sb_q.pop_front();
                total++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== want) begin
                    bad++;
                    $display("FAIL collision_read_first got=%h/%b want=%h/1", bus.rd_data,
                             bus.rd_valid, want);
                end
            end
        end
        clear_inputs();
        total++;
        if (bus.done !== 1'b1 || bus.wr_count !== 4'd8) begin
            bad++;
            $display("FAIL collision_done got=%b/%0d want=1/8", bus.done, bus.wr_count);
        end
        test_readback("collision");
    endtask

`ifdef CAPTURE_DECIM_EN
    task automatic test_decim();
        bus.decim = 8'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int s = 0; s < 22; s++) begin
            bus.in_valid = 1'b1;
            bus.trig     = (s == 0);
            bus.in_data  = 16'(s);
            if (s % 3 == 0) exp_mem[s/3] = 16'(s);
            step();
            total++;
            if (bus.done !== (s == 21) || bus.wr_count !== 4'(s / 3 + 1)) begin
                bad++;
                $display("FAIL decim_step[%0d] got=%b/%0d want=%b/%0d", s, bus.done,
                         bus.wr_count, (s == 21), s / 3 + 1);
            end
        end
        clear_inputs();
        test_readback("decim");
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;
        test_reset();
        test_basic();
        test_trig_qual();
        test_gapped();
        test_abort();
        test_collision();
`ifdef CAPTURE_DECIM_EN
        test_decim();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
